// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package : fifo_pkg
// Brief   : Shared FIFO helpers: pointer width, occupancy math, status struct.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [31:0] calc_usedw(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int          pw
    );
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module : fifo_ram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register is cleared so the FIFO output powers up at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sc_fifo.sv
`default_nettype none
// ============================================================================
// Module : sc_fifo
// Brief  : Single-clock FIFO with show-ahead/normal modes and sticky errors.
// Rev    : 1.0  initial release
// ============================================================================
module sc_fifo
    import fifo_pkg::*;
#(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int REGISTER_OUTPUT    = 0,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int                 c_PTR_W  = ptr_width(AWIDTH);
    localparam logic [c_PTR_W-1:0] c_AF_THR = c_PTR_W'(ALMOST_FULL_VALUE);
    localparam logic [c_PTR_W-1:0] c_AE_THR = c_PTR_W'(ALMOST_EMPTY_VALUE);

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] w_usedw;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               w_wr_acc, w_rd_acc;
    fifo_status_t       w_status;
    logic [AWIDTH-1:0]  w_raddr;
    logic               w_re;
    logic [DWIDTH-1:0]  w_ram_q;

    assign w_usedw = c_PTR_W'(calc_usedw(32'(wr_ptr_q), 32'(rd_ptr_q), c_PTR_W));

    always_comb begin
        w_status.empty        = (wr_ptr_q == rd_ptr_q);
        w_status.full         = (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]) &&
                                (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]);
        w_status.almost_full  = (w_usedw >= c_AF_THR);
        w_status.almost_empty = (w_usedw <  c_AE_THR);
    end

    assign w_wr_acc = wrreq_i && !w_status.full;
    assign w_rd_acc = rdreq_i && !w_status.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        // A fresh violation outranks a clear in the same cycle.
        if (clr_err_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wrreq_i && w_status.full)  ovf_d = 1'b1;
        if (rdreq_i && w_status.empty) udf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (srst_i),
        .we_i    (w_wr_acc && !srst_i),
        .waddr_i (wr_ptr_q[AWIDTH-1:0]),
        .wdata_i (data_i),
        .re_i    (w_re),
        .raddr_i (w_raddr),
        .rdata_o (w_ram_q)
    );

    if (SHOWAHEAD != 0) begin : g_showahead
        logic              byp_q;
        logic [DWIDTH-1:0] byp_data_q;

        // Prefetch the next head; a write landing on that slot is forwarded.
        assign w_raddr = rd_ptr_d[AWIDTH-1:0];
        assign w_re    = w_wr_acc || w_rd_acc;

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                byp_q      <= 1'b0;
                byp_data_q <= '0;
            end else if (w_re) begin
                byp_q      <= w_wr_acc && (wr_ptr_q[AWIDTH-1:0] == rd_ptr_d[AWIDTH-1:0]);
                byp_data_q <= data_i;
            end
        end

        assign q_o = byp_q ? byp_data_q : w_ram_q;
    end else begin : g_normal
        assign w_raddr = rd_ptr_q[AWIDTH-1:0];
        assign w_re    = w_rd_acc;

        if (REGISTER_OUTPUT != 0) begin : g_outreg
            logic              vld_q;
            logic [DWIDTH-1:0] out_q;

            always_ff @(posedge clk_i) begin
                if (srst_i) begin
                    vld_q <= 1'b0;
                    out_q <= '0;
                end else begin
                    vld_q <= w_rd_acc;
                    if (vld_q) out_q <= w_ram_q;
                end
            end

            assign q_o = out_q;
        end else begin : g_direct
            assign q_o = w_ram_q;
        end
    end

    assign empty_o        = w_status.empty;
    assign full_o         = w_status.full;
    assign almost_full_o  = w_status.almost_full;
    assign almost_empty_o = w_status.almost_empty;
    assign usedw_o        = w_usedw;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule
`default_nettype wire
